// File: rtl/srl_cascade_pkg.sv
`default_nettype none
// ============================================================================
// Module      : srl_cascade_pkg
// Description : Shared limits, the address-width helper and the channel-input
//               select type for the addressable shift-register cascade bank.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package srl_cascade_pkg;

  // Upper bounds checked when the bank is elaborated
  localparam int SRL_MAX_CHANNELS = 16;
  localparam int SRL_MAX_DEPTH    = 64;

  // Where a channel takes its serial input from
  typedef enum logic {
    SRC_D       = 1'b0,  // the channel's own d input
    SRC_CASCADE = 1'b1   // the previous channel's last tap
  } srl_src_e;

  // Read-address width for a channel of the given depth (never below 1 bit)
  function automatic int srl_addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/srl_cascade_chan.sv
`default_nettype none
// ============================================================================
// Module      : srl_cascade_chan
// Description : One addressable shift-register channel. DEPTH storage bits
//               shifted on ce, combinational addressed read with addresses
//               beyond the last tap reading as zero, plus the last tap.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module srl_cascade_chan
  import srl_cascade_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = srl_addr_w(DEPTH),
  parameter bit INIT   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              din,
  input  logic [ADDR_W-1:0] addr,
  output logic              q,
  output logic              q_last
);

  // Address limit widened by one bit so DEPTH itself is representable
  localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);

  // Tap 0 is the newest bit, tap DEPTH-1 the oldest
  logic [DEPTH-1:0] r_stage;
  logic             w_in_range;

  // Shift storage: new bit enters tap 0, every tap advances by one per ce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= {DEPTH{INIT}};
    end else if (ce) begin
      r_stage <= {r_stage[DEPTH-2:0], din};
    end
  end

  // Non-power-of-two depths leave unused address codes; they read as zero
  assign w_in_range = ({1'b0, addr} < c_depth);
  assign q          = w_in_range ? r_stage[addr] : 1'b0;
  assign q_last     = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/srl_cascade_bank.sv
`default_nettype none
// ============================================================================
// Module      : srl_cascade_bank
// Description : Bank of CHANNELS addressable shift registers, DEPTH taps each.
//               Each channel is fed either from its own d bit or from the
//               previous channel's last tap. A shift counter reports when the
//               storage has been fully primed, and a strobe-captured readback
//               register serialises {q_last, q} MSB first on so.
// Options     : SRL_CASCADE_OUTPUT_REG_EN - when defined, q and q_last are
//               registered every clock (1-cycle read latency); the cascade
//               path always uses the unregistered last tap.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module srl_cascade_bank
  import srl_cascade_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = srl_addr_w(DEPTH),
  parameter bit INIT     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ce,
  input  logic [CHANNELS-1:0]          d,
  input  logic [CHANNELS-1:0]          cascade_en,
  input  logic [CHANNELS*ADDR_W-1:0]   addr,
  output logic [CHANNELS-1:0]          q,
  output logic [CHANNELS-1:0]          q_last,
  output logic                         primed,
  input  logic                         cap_stb,
  output logic                         so
);

  localparam int              c_rb_w    = 2 * CHANNELS;
  localparam logic [ADDR_W:0] c_cnt_max = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] c_cnt_one = (ADDR_W + 1)'(1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter range checks
  // --------------------------------------------------------------------------
  generate
    if (CHANNELS < 1 || CHANNELS > SRL_MAX_CHANNELS) begin : g_bad_channels
      $error("srl_cascade_bank: CHANNELS out of range 1..16");
    end
    if (DEPTH < 2 || DEPTH > SRL_MAX_DEPTH) begin : g_bad_depth
      $error("srl_cascade_bank: DEPTH out of range 2..64");
    end
    if (ADDR_W < srl_addr_w(DEPTH)) begin : g_bad_addr_w
      $error("srl_cascade_bank: ADDR_W too narrow for DEPTH");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Channel array with input selection
  // --------------------------------------------------------------------------
  srl_src_e            w_src [CHANNELS];
  logic [CHANNELS-1:0] w_in;
  logic [CHANNELS-1:0] w_q;
  logic [CHANNELS-1:0] w_last;

  // Channel 0 has no predecessor, so its cascade enable has no effect
  logic w_unused_casc0;
  assign w_unused_casc0 = cascade_en[0];

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      if (k == 0) begin : g_head
        assign w_src[k] = SRC_D;
        assign w_in[k]  = d[k];
      end else begin : g_link
        // The cascade source is the pre-edge last tap of channel k-1, so a
        // bit advances exactly one tap per enabled cycle across the chain.
        assign w_src[k] = cascade_en[k] ? SRC_CASCADE : SRC_D;
        assign w_in[k]  = (w_src[k] == SRC_CASCADE) ? w_last[k-1] : d[k];
      end

      srl_cascade_chan #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .INIT   (INIT)
      ) u_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .din    (w_in[k]),
        .addr   (addr[k*ADDR_W +: ADDR_W]),
        .q      (w_q[k]),
        .q_last (w_last[k])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Read outputs
  // --------------------------------------------------------------------------
`ifdef SRL_CASCADE_OUTPUT_REG_EN
  logic [CHANNELS-1:0] r_q;
  logic [CHANNELS-1:0] r_q_last;

  // Output registers load every clock, independent of ce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q      <= '0;
      r_q_last <= '0;
    end else begin
      r_q      <= w_q;
      r_q_last <= w_last;
    end
  end

  assign q      = r_q;
  assign q_last = r_q_last;
`else
  assign q      = w_q;
  assign q_last = w_last;
`endif

  // --------------------------------------------------------------------------
  // Shift counter and primed flag
  // --------------------------------------------------------------------------
  logic [ADDR_W:0] r_count;
  logic [ADDR_W:0] w_count_inc;
  logic            r_primed;

  assign w_count_inc = r_count + c_cnt_one;

  // Count enabled shifts, saturating at DEPTH; primed rises on the DEPTH-th
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_primed <= 1'b0;
    end else if (ce && (r_count != c_cnt_max)) begin
      r_count  <= w_count_inc;
      r_primed <= (w_count_inc == c_cnt_max);
    end
  end

  assign primed = r_primed;

  // --------------------------------------------------------------------------
  // Serial readback
  // --------------------------------------------------------------------------
  logic [c_rb_w-1:0] r_rb;

  // Capture {q_last, q} on strobe, otherwise shift out MSB first, zero-filling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rb <= '0;
    end else if (cap_stb) begin
      r_rb <= {q_last, q};
    end else begin
      r_rb <= {r_rb[c_rb_w-2:0], 1'b0};
    end
  end

  assign so = r_rb[c_rb_w-1];

endmodule
`default_nettype wire
